// File: rtl/product_accumulator.sv
// Sums a block of len signed products into a wide accumulator and presents the result.
// Latency: result valid one cycle after the final accepted product.
// Backpressure: in_ready only while accumulating; result held until out_ready.
module product_accumulator #(
    parameter int W     = 64,
    parameter int LEN_W = 8,
    parameter int ACC_W = 72    // must be >= W + LEN_W so no legal block can overflow
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_product,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [LEN_W-1:0] out_count,
    output logic             busy,
    output logic             err_stray
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [LEN_W-1:0] count_q;
    logic [LEN_W-1:0] count_d;
    logic [LEN_W-1:0] len_q;
    logic             err_q;
    logic             last_d;
    logic [ACC_W-1:0] prod_ext;

    // Sign-extend the incoming product and form the next accumulator / count values.
    always_comb begin
        prod_ext = {{(ACC_W-W){in_product[W-1]}}, in_product};
        acc_d    = acc_q + prod_ext;
        count_d  = count_q + LEN_W'(1);
        last_d   = (count_d == len_q);
    end

    // Block FSM and datapath; reset overrides every handshake and start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            count_q <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            // Products offered outside ACCUM are dropped but remembered as a protocol error.
            if (in_valid && (state_q != ACCUM)) begin
                err_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_q   <= '0;
                        count_q <= '0;
                        len_q   <= len;
                        state_q <= (len == '0) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc_q   <= acc_d;
                        count_q <= count_d;
                        if (last_d) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    // start in the handshake cycle is ignored: we only look at it in IDLE.
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs come straight from state; a pending synchronous reset blanks them immediately.
    always_comb begin
        in_ready  = (state_q == ACCUM) && !reset;
        out_valid = (state_q == DONE) && !reset;
        busy      = (state_q != IDLE) && !reset;
        out_acc   = out_valid ? acc_q : '0;
        out_count = out_valid ? count_q : '0;
        err_stray = err_q;
    end

endmodule

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;

    localparam int W     = 64;
    localparam int LEN_W = 8;
    localparam int ACC_W = 72;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_product;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic [LEN_W-1:0] out_count;
    logic             busy;
    logic             err_stray;

    int n_cmp = 0;
    int n_bad = 0;

    product_accumulator #(.W(W), .LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_product(in_product),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_count (out_count),
        .busy      (busy),
        .err_stray (err_stray)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Describes a block as "collecting products towards a target" or "holding a result".
    bit                      m_collecting = 0;
    bit                      m_have_result = 0;
    int                      m_target = 0;
    int                      m_got = 0;
    logic signed [ACC_W-1:0] m_sum = '0;
    bit                      m_err = 0;

    always @(posedge clk) begin
        logic signed [W-1:0]     p;
        logic signed [ACC_W-1:0] pext;
        p    = in_product;
        pext = p;
        if (reset) begin
            m_collecting  = 0;
            m_have_result = 0;
            m_target      = 0;
            m_got         = 0;
            m_sum         = '0;
            m_err         = 0;
        end else if (m_have_result) begin
            if (in_valid) m_err = 1;
            if (out_ready) m_have_result = 0;
        end else if (m_collecting) begin
            if (in_valid) begin
                m_sum = m_sum + pext;
                m_got = m_got + 1;
                if (m_got == m_target) begin
                    m_collecting  = 0;
                    m_have_result = 1;
                end
            end
        end else begin
            if (in_valid) m_err = 1;
            if (start) begin
                m_sum    = '0;
                m_got    = 0;
                m_target = int'(len);
                if (len == 0) m_have_result = 1;
                else          m_collecting  = 1;
            end
        end
    end

    task automatic check(input string name, input logic [ACC_W-1:0] act, input logic [ACC_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every cycle on the falling edge, away from the active edge.
    always @(negedge clk) begin
        bit ov;
        ov = m_have_result && !reset;
        check("in_ready",  {71'd0, in_ready},  {71'd0, m_collecting && !reset});
        check("out_valid", {71'd0, out_valid}, {71'd0, ov});
        check("busy",      {71'd0, busy},      {71'd0, (m_collecting || m_have_result) && !reset});
        check("out_acc",   out_acc,            ov ? m_sum : '0);
        check("out_count", {64'd0, out_count}, ov ? ACC_W'(m_got) : '0);
        check("err_stray", {71'd0, err_stray}, {71'd0, m_err});
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_block(input int n);
        start = 1'b1;
        len   = LEN_W'(n);
        tick();
        start = 1'b0;
        len   = '0;
    endtask

    task automatic send(input logic [W-1:0] p);
        in_valid   = 1'b1;
        in_product = p;
        tick();
        in_valid   = 1'b0;
        in_product = '0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
        in_product = '0; out_ready = 1'b0;
        tick(); tick();
        check("rst_in_ready",  {71'd0, in_ready},  '0);
        check("rst_out_valid", {71'd0, out_valid}, '0);
        check("rst_busy",      {71'd0, busy},      '0);
        reset = 1'b0;
        tick();

        // Three products back to back: 5 - 7 + 100 = 98.
        begin_block(3);
        send(64'd5);
        send(-64'sd7);
        send(64'd100);
        check("b1_valid", {71'd0, out_valid}, 72'd1);
        check("b1_acc",   out_acc,            72'd98);
        check("b1_count", {64'd0, out_count}, 72'd3);
        handshake();
        check("b1_idle", {71'd0, busy}, '0);

        // Two max positives with a gap: no early result.
        begin_block(2);
        send(64'h7FFF_FFFF_FFFF_FFFF);
        tick();
        check("b2_gap_valid", {71'd0, out_valid}, '0);
        tick();
        send(64'h7FFF_FFFF_FFFF_FFFF);
        check("b2_acc",   out_acc, 72'h00_FFFF_FFFF_FFFF_FFFE);
        check("b2_count", {64'd0, out_count}, 72'd2);
        handshake();

        // Empty block goes straight to a zero result.
        begin_block(0);
        check("b3_valid", {71'd0, out_valid}, 72'd1);
        check("b3_acc",   out_acc,            '0);
        check("b3_ready", {71'd0, in_ready},  '0);
        handshake();

        // Single -1, result held five cycles while start is ignored.
        begin_block(1);
        send('1);
        start = 1'b1; len = 8'd4;
        for (int i = 0; i < 5; i++) begin
            check("b4_hold_valid", {71'd0, out_valid}, 72'd1);
            check("b4_hold_acc",   out_acc, {ACC_W{1'b1}});
            tick();
        end
        handshake();
        start = 1'b0; len = '0;
        check("b4_after_busy", {71'd0, busy}, '0);

        // Stray product in IDLE, then a full block keeps the sticky flag.
        in_valid = 1'b1; in_product = 64'd1000;
        tick();
        in_valid = 1'b0; in_product = '0;
        check("b5_err", {71'd0, err_stray}, 72'd1);
        begin_block(2);
        send(64'd3);
        send(64'd4);
        check("b5_acc", out_acc, 72'd7);
        check("b5_err_kept", {71'd0, err_stray}, 72'd1);
        handshake();

        // Reset in the middle of a four-product block.
        begin_block(4);
        send(64'd1);
        send(64'd2);
        reset = 1'b1;
        tick();
        check("b6_rst_busy",  {71'd0, busy},      '0);
        check("b6_rst_ready", {71'd0, in_ready},  '0);
        check("b6_rst_err",   {71'd0, err_stray}, '0);
        reset = 1'b0;
        tick();
        begin_block(1);
        send(64'd9);
        check("b6_acc",   out_acc, 72'd9);
        check("b6_count", {64'd0, out_count}, 72'd1);
        handshake();
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
